// File: rtl/rob_multiport_if.sv
// Bundle of dispatch, writeback, retire and status signals between the backend
// pipeline and the reorder buffer.
interface rob_multiport_if #(
    parameter int ENTRIES        = 64,
    parameter int DISPATCH_WIDTH = 2,
    parameter int WB_PORTS       = 3,
    parameter int RETIRE_WIDTH   = 4,
    parameter int XLEN           = 32,
    parameter int AREG_BITS      = 5
);
    localparam int IDXW = $clog2(ENTRIES);

    // Dispatch handshake: the whole group of disp_valid lanes is taken on a
    // rising clk edge when disp_ready is high and neither flush nor exc_valid is
    // high. disp_ready never depends on disp_valid; lanes offered while
    // disp_ready is low are not taken and must be offered again.
    logic [DISPATCH_WIDTH-1:0]           disp_valid;
    logic [DISPATCH_WIDTH-1:0]           disp_has_dst;
    logic [DISPATCH_WIDTH*AREG_BITS-1:0] disp_dst;
    logic                                disp_ready;
    logic [DISPATCH_WIDTH*IDXW-1:0]      disp_idx;

    logic [WB_PORTS-1:0]                 wb_valid;
    logic [WB_PORTS*IDXW-1:0]            wb_idx;
    logic [WB_PORTS*XLEN-1:0]            wb_val;
    logic [WB_PORTS-1:0]                 wb_exc;

    logic [RETIRE_WIDTH-1:0]             ret_valid;
    logic [RETIRE_WIDTH-1:0]             ret_has_dst;
    logic [RETIRE_WIDTH*AREG_BITS-1:0]   ret_dst;
    logic [RETIRE_WIDTH*XLEN-1:0]        ret_val;

    logic                                exc_valid;
    logic [IDXW-1:0]                     exc_idx;
    logic                                flush;

    logic [IDXW:0]                       count;
    logic                                empty;
    logic                                full;

    // Raw pointers, wrap bit included.
    logic [IDXW:0]                       dbg_head;
    logic [IDXW:0]                       dbg_tail;

    modport master (
        output disp_valid, disp_has_dst, disp_dst,
        output wb_valid, wb_idx, wb_val, wb_exc,
        output flush,
        input  disp_ready, disp_idx,
        input  ret_valid, ret_has_dst, ret_dst, ret_val,
        input  exc_valid, exc_idx,
        input  count, empty, full, dbg_head, dbg_tail
    );

    modport slave (
        input  disp_valid, disp_has_dst, disp_dst,
        input  wb_valid, wb_idx, wb_val, wb_exc,
        input  flush,
        output disp_ready, disp_idx,
        output ret_valid, ret_has_dst, ret_dst, ret_val,
        output exc_valid, exc_idx,
        output count, empty, full, dbg_head, dbg_tail
    );
endinterface

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: packed multi-lane allocation, out-of-order
// completion, in-order retire of up to RETIRE_WIDTH entries, exception/flush.
module rob_multiport #(
    parameter int ENTRIES        = 64,
    parameter int DISPATCH_WIDTH = 2,
    parameter int WB_PORTS       = 3,
    parameter int RETIRE_WIDTH   = 4,
    parameter int XLEN           = 32,
    parameter int AREG_BITS      = 5
) (
    input logic          clk,
    input logic          rst,
    rob_multiport_if.slave rob
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int PW   = IDXW + 1;
    localparam logic [PW-1:0] DEPTH = PW'(ENTRIES);
    localparam logic [PW-1:0] DISP_W = PW'(DISPATCH_WIDTH);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW-1:0]        count;
    logic [PW-1:0]        free_slots;

    logic [ENTRIES-1:0]   e_alloc;
    logic [ENTRIES-1:0]   e_done;
    logic [ENTRIES-1:0]   e_exc;
    logic [ENTRIES-1:0]   e_has_dst;
    logic [AREG_BITS-1:0] e_dst [ENTRIES];
    logic [XLEN-1:0]      e_val [ENTRIES];

    logic [IDXW-1:0]      head_idx;
    logic                 exc_valid;
    logic                 disp_ready;
    logic                 disp_accept;

    logic [PW-1:0]        disp_cnt;
    logic [IDXW-1:0]      disp_slot [DISPATCH_WIDTH];

    logic [PW-1:0]        ret_cnt;
    logic                 ret_run;
    logic [RETIRE_WIDTH-1:0] ret_valid;
    logic [IDXW-1:0]      ret_slot [RETIRE_WIDTH];

    // Pointers carry one extra wrap bit, so tail - head spans 0..ENTRIES.
    assign count      = tail - head;
    assign free_slots = DEPTH - count;
    assign disp_ready = free_slots >= DISP_W;
    assign head_idx   = head[IDXW-1:0];
    assign exc_valid  = e_alloc[head_idx] & e_done[head_idx] & e_exc[head_idx];
    assign disp_accept = disp_ready & ~rob.flush & ~exc_valid;

    // Valid lanes are packed: each lane takes tail plus the valid lanes below it.
    always_comb begin
        disp_cnt = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            disp_slot[i] = tail[IDXW-1:0] + disp_cnt[IDXW-1:0];
            if (rob.disp_valid[i]) begin
                disp_cnt = disp_cnt + ONE;
            end
        end
    end

    // Retire lanes form an unbroken run of completed, non-excepting entries from head.
    always_comb begin
        ret_cnt   = '0;
        ret_valid = '0;
        ret_run   = ~exc_valid;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            ret_slot[i]  = head_idx + IDXW'(i);
            ret_run      = ret_run & (PW'(i) < count) & e_alloc[ret_slot[i]]
                         & e_done[ret_slot[i]] & ~e_exc[ret_slot[i]];
            ret_valid[i] = ret_run;
            if (ret_run) begin
                ret_cnt = ret_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            e_alloc <= '0;
            e_done  <= '0;
            e_exc   <= '0;
        end else if (exc_valid) begin
            tail    <= head;
            e_alloc <= '0;
            e_done  <= '0;
            e_exc   <= '0;
        end else if (rob.flush) begin
            // Retirements of this cycle still commit before the window is dropped.
            head    <= head + ret_cnt;
            tail    <= head + ret_cnt;
            e_alloc <= '0;
            e_done  <= '0;
            e_exc   <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rob.wb_valid[p] && e_alloc[rob.wb_idx[p*IDXW +: IDXW]]) begin
                    e_done[rob.wb_idx[p*IDXW +: IDXW]] <= 1'b1;
                    e_exc[rob.wb_idx[p*IDXW +: IDXW]]  <= rob.wb_exc[p];
                    e_val[rob.wb_idx[p*IDXW +: IDXW]]  <= rob.wb_val[p*XLEN +: XLEN];
                end
            end
            for (int r = 0; r < RETIRE_WIDTH; r++) begin
                if (ret_valid[r]) begin
                    e_alloc[ret_slot[r]] <= 1'b0;
                    e_done[ret_slot[r]]  <= 1'b0;
                end
            end
            if (disp_accept) begin
                for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                    if (rob.disp_valid[i]) begin
                        e_alloc[disp_slot[i]]   <= 1'b1;
                        e_done[disp_slot[i]]    <= 1'b0;
                        e_exc[disp_slot[i]]     <= 1'b0;
                        e_has_dst[disp_slot[i]] <= rob.disp_has_dst[i];
                        e_dst[disp_slot[i]]     <= rob.disp_dst[i*AREG_BITS +: AREG_BITS];
                    end
                end
                tail <= tail + disp_cnt;
            end
            head <= head + ret_cnt;
        end
    end

    for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_disp
        assign rob.disp_idx[g*IDXW +: IDXW] = disp_slot[g];
    end

    for (genvar g = 0; g < RETIRE_WIDTH; g++) begin : g_ret
        assign rob.ret_has_dst[g]                   = e_has_dst[ret_slot[g]];
        assign rob.ret_dst[g*AREG_BITS +: AREG_BITS] = e_dst[ret_slot[g]];
        assign rob.ret_val[g*XLEN +: XLEN]           = e_val[ret_slot[g]];
    end

    assign rob.disp_ready = disp_ready;
    assign rob.ret_valid  = ret_valid;
    assign rob.exc_valid  = exc_valid;
    assign rob.exc_idx    = head_idx;
    assign rob.count      = count;
    assign rob.empty      = (count == '0);
    assign rob.full       = (count == DEPTH);
    assign rob.dbg_head   = head;
    assign rob.dbg_tail   = tail;
endmodule
